// File: rtl/pipe_stage_reg.sv
//==============================================================================
// Module   : pipe_stage_reg
// Purpose  : Elastic valid/ready pipeline stage with flush, bubble masking of
//            the control bus and a saturating stall-cycle counter.
//            Define PIPE_SKID_EN for a 2-entry skid buffer with registered
//            in_ready; otherwise a single-entry stage is built.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              w_in_fire;
    logic              w_out_fire;
    logic              r_main_vld;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_main_vld & out_ready;

    assign out_valid  = r_main_vld;
    assign out_data   = r_main_data;
    // Control is masked on bubbles so stale write enables never leak downstream
    assign out_ctrl   = r_main_vld ? r_main_ctrl : '0;
    assign stall_cnt  = r_stall_cnt;

`ifdef PIPE_SKID_EN
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_SKID  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_in_fire) w_state_nxt = S_FULL;
                S_FULL: begin
                    if (w_in_fire && !w_out_fire)
                        w_state_nxt = S_SKID;
                    else if (!w_in_fire && w_out_fire)
                        w_state_nxt = S_EMPTY;
                end
                S_SKID:  if (w_out_fire) w_state_nxt = S_FULL;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b0;
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_SKID);
            r_main_vld <= (w_state_nxt != S_EMPTY);
            if (!flush) begin
                if (r_state == S_SKID) begin
                    if (w_out_fire) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                    end
                end else if (w_in_fire && (r_state == S_EMPTY || w_out_fire)) begin
                    r_main_data <= in_data;
                    r_main_ctrl <= in_ctrl;
                end else if (w_in_fire) begin
                    r_skid_data <= in_data;
                    r_skid_ctrl <= in_ctrl;
                end
            end
        end
    end

    // Registered ready: no combinational path from out_ready to in_ready
    assign in_ready = r_in_ready & ~rst;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else if (flush) begin
            r_main_vld  <= 1'b0;
        end else if (w_in_fire) begin
            r_main_vld  <= 1'b1;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
        end else if (w_out_fire) begin
            r_main_vld  <= 1'b0;
        end
    end

    assign in_ready = (~r_main_vld | out_ready) & ~rst;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_main_vld && !out_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//==============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg (both build modes).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
    localparam int c_EXP_ACC_BP = 2;
    localparam int c_EXP_ACC_FL = 2;
`else
    localparam int c_EXP_ACC_BP = 1;
    localparam int c_EXP_ACC_FL = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] tx[$];
    logic [31:0] rx[$];
    int          idx;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle: offer tx[idx], log whatever the stage hands out
    task automatic cycle();
        logic f_in;
        if (idx < tx.size()) begin
            in_valid = 1'b1;
            in_data  = tx[idx];
        end else begin
            in_valid = 1'b0;
        end
        in_ctrl = 16'h0005;
        #1;
        f_in = in_valid & in_ready;
        if (out_valid && out_ready) rx.push_back(out_data);
        @(posedge clk);
        #1;
        if (f_in) idx++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_bp [3];
        int          seen;
        int          n;
        exp_bp[0] = 32'hA;
        exp_bp[1] = 32'hB;
        exp_bp[2] = 32'hC;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        flush = 1'b0; out_ready = 1'b0; idx = 0;

        // Reset
        tick();
        chk("rdy_in_rst", in_ready, 0);
        tick();
        chk("rst_vld", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_cnt", stall_cnt, 0);
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", in_ready, 1);

        // Streaming at full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i; in_ctrl = 16'h0003;
            tick();
            chk("strm_vld", out_valid, 1);
            chk("strm_data", out_data, i);
            chk("strm_ctrl", out_ctrl, 16'h0003);
        end
        in_valid = 1'b0;
        tick();
        chk("strm_drain", out_valid, 0);
        chk("strm_cnt", stall_cnt, 0);

        // Bubble masking
        in_ctrl = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bub_vld", out_valid, 0);
            chk("bub_ctrl", out_ctrl, 0);
            chk("bub_data", out_data, 8);
        end

        // Back-pressure
        out_ready = 1'b0;
        tx = '{32'hA, 32'hB, 32'hC};
        idx = 0;
        rx.delete();
        cycle();
        chk("bp_first", out_data, 32'hA);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold", out_data, 32'hA);
        end
        chk("bp_cnt", stall_cnt, 3);
        chk("bp_rdy", in_ready, 0);
        chk("bp_acc", idx, c_EXP_ACC_BP);
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("bp_rx_n", rx.size(), 3);
        for (int k = 0; k < 3; k++)
            chk("bp_rx", (k < rx.size()) ? rx[k] : 32'hDEAD_BEEF, exp_bp[k]);
        chk("bp_cnt_rel", stall_cnt, 3);

        // Flush with entries held
        out_ready = 1'b0;
        tx = '{32'h55, 32'h66};
        idx = 0;
        cycle();
        cycle();
        chk("fl_main", out_data, 32'h55);
        chk("fl_cnt", stall_cnt, 4);
        chk("fl_acc", idx, c_EXP_ACC_FL);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'hFFFF;
        tick();
        chk("fl_vld", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_cnt_hold", stall_cnt, 4);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        seen = 0;
        repeat (3) begin
            tick();
            if (out_valid) seen++;
        end
        chk("fl_nothing_out", seen, 0);

        // Stall counter saturation
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h99; in_ctrl = 16'h0001;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("sat_14", stall_cnt, 14);
        tick();
        chk("sat_15", stall_cnt, 15);
        repeat (9) tick();
        chk("sat_hold", stall_cnt, 15);
        chk("sat_data", out_data, 32'h99);

        // Reset while holding entries
        in_valid = 1'b1; in_data = 32'hAB;
        tick();
        chk("pre_rst_rdy", in_ready, 0);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("mrst_vld", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_ctrl", out_ctrl, 0);
        chk("mrst_cnt", stall_cnt, 0);
        chk("mrst_rdy", in_ready, 0);
        rst = 1'b0;
        tx = '{32'h1234};
        idx = 0;
        out_ready = 1'b1;
        rx.delete();
        n = 0;
        while (idx < 1 && n < 5) begin
            cycle();
            n++;
        end
        in_valid = 1'b0;
        chk("post_acc", idx, 1);
        chk("post_vld", out_valid, 1);
        chk("post_data", out_data, 32'h1234);
        chk("post_ctrl", out_ctrl, 16'h0005);
        tick();
        chk("post_drain", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed EXE/MEM latch. One generic pipeline stage between any two CPU stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Adds a valid/ready handshake, back-pressure (stall), synchronous flush and masking of control fields on bubbles.
- Adds a saturating stall-cycle counter for performance analysis.
- The payload is split into a data bus and a control bus. The control bus carries write enables and selects, and it is forced to zero whenever the stage holds no valid entry.

Parameters:
- DATA_W, 32: payload data width (ALU result, operands, addresses concatenated by the instantiating stage).
- CTRL_W, 16: control width (rf/hi/lo/dmem write enables, selects).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  discard all held entries (branch mispredict / exception).
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts an entry.
- out_data  out  DATA_W  held data payload.
- out_ctrl  out  CTRL_W  held control payload; zero when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset is synchronous and active-high on clk; clock port clk, reset port rst.
- rst=1 at a rising edge sets:
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - All internal valid bits = 0; state = EMPTY.
- in_ready is 0 while rst=1.
- Reset mid-transfer drops every held entry with no partial output.
- Handshake:
  - Input transfer ("in fire") = in_valid & in_ready at an edge.
  - Output transfer ("out fire") = out_valid & out_ready at an edge.
  - in_data and in_ctrl are sampled only on in fire.
  - out_data and out_ctrl stay stable while out_valid=1 and out_ready=0.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle). Sustained throughput is 1 entry per cycle when out_ready=1.
- Bubble masking: out_ctrl = 0 whenever out_valid=0. out_data holds its last value during a bubble (no clear, to save power).
- Flush:
  - flush=1 at an edge clears all valid bits and returns the state to EMPTY.
  - An in_valid presented in the same cycle is discarded, even if in_ready=1.
  - Flush takes priority over both capture and drain.
  - out_valid=0 on the cycle after the flush.
- stall_cnt:
  - Increments by 1 at each edge where out_valid=1 and out_ready=0 and flush=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- No entry is ever duplicated or lost except by flush or rst.

Optional Feature:
- Macro PIPE_SKID_EN.
- Defined: 2-entry skid buffer; in_ready is a registered output (no combinational path from out_ready).
  - States:
    - EMPTY (in_ready=1, out_valid=0)
    - FULL (main valid, in_ready=1)
    - SKID (main+skid valid, in_ready=0)
  - Transitions:
    - EMPTY --in fire--> FULL.
    - FULL, in fire & out fire: stays FULL, main <= input.
    - FULL, in fire & no out fire: -> SKID, skid <= input.
    - FULL, out fire only: -> EMPTY.
    - SKID --out fire--> FULL, main <= skid, in the same edge.
    - Any state --flush--> EMPTY.
  - in_ready = 1 the cycle after rst deasserts.
- Undefined: single entry.
  - in_ready = ~out_valid | out_ready, combinational.
  - On in fire the register loads; otherwise, on out fire, it empties.
  - No skid register is generated.

Test Plan:
- Streaming, out_ready=1: in_data = 0x00000001..0x00000008 on 8 consecutive cycles with in_ctrl=0x0003 -> out_data 1..8 each one cycle later, out_valid continuous, stall_cnt=0.
- Back-pressure: send 0xA, 0xB, 0xC, then hold out_ready=0 for 3 cycles.
  - PIPE_SKID_EN: in_ready drops after the 2nd held entry; 0xC is not accepted until a drain; stall_cnt=3.
  - Release -> out sequence 0xA, 0xB, 0xC, no loss or duplicate.
- Flush with entries held: stage holds 0x55 (and skid 0x66) with out_ready=0; assert flush together with in_valid carrying 0x77 -> next cycle out_valid=0, out_ctrl=0; 0x77 never appears at the output.
- Bubble masking: in_ctrl=0xFFFF with in_valid=0 for 2 cycles -> out_ctrl=0x0000, out_valid=0, and out_data unchanged from the prior value.
- Saturation: CNT_W=4, out_ready=0 with a valid entry for 20 cycles -> stall_cnt reaches 15 and holds at 15.
- Reset mid-operation: rst=1 for one edge while SKID is full -> out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0; next accepted entry 0x1234 emerges normally one cycle after acceptance.
